// File: rtl/decoder_pkg.sv
// Shared definitions for decoder_nx_seq: controller state encoding and a one-hot helper.
package decoder_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIRECT = 2'd1,
    SCAN   = 2'd2
  } state_t;

  // Widest select the helper supports; callers size-cast the result down to 2**N.
  localparam int MAX_N = 10;

  function automatic logic [2**MAX_N-1:0] onehot(input logic [MAX_N-1:0] sel);
    logic [2**MAX_N-1:0] v;
    v      = '0;
    v[sel] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/decoder_nx_seq_dwell_counter.sv
// Dwell timer for scan mode: tick is high on the last cycle of each DWELL-cycle dwell.
module dwell_counter #(
  parameter int DWELL = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CW-1:0] LAST = CW'(DWELL - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cnt <= '0;
    else if (clr || cnt == LAST)
      cnt <= '0;
    else
      cnt <= cnt + 1'b1;
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/decoder_nx_seq.sv
// Registered N-to-2^N one-hot decoder with direct and dwell-timed scan modes.
// Define DEC_SCAN_MASK_EN to add the per-channel scan skip mask input.
module decoder_nx_seq
  import decoder_pkg::*;
#(
  parameter int N     = 3,
  parameter int DWELL = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          mode,
  input  logic [N-1:0]  in,
`ifdef DEC_SCAN_MASK_EN
  input  logic [2**N-1:0] mask,
`endif
  output logic [2**N-1:0] out,
  output logic [N-1:0]  idx,
  output logic          wrap
);

  localparam int W = 2**N;

  state_t        state, state_next;
  logic [W-1:0]  out_next;
  logic [N-1:0]  idx_next;
  logic          wrap_next;
  logic [W-1:0]  live;
  logic          any_live;
  logic          stalled;
  logic          tick;
  logic          clr;
  logic [N-1:0]  first_idx;
  logic [N-1:0]  adv_idx;

`ifdef DEC_SCAN_MASK_EN
  assign live = ~mask;
`else
  assign live = '1;
`endif

  assign any_live = |live;
  // In SCAN an all-zero output means either just entered or parked on an all-masked set.
  assign stalled  = ~|out;
  assign clr      = (state != SCAN) || stalled;

  dwell_counter #(.DWELL(DWELL)) u_dwell (
    .clk  (clk),
    .rst  (rst),
    .clr  (clr),
    .tick (tick)
  );

  // Lowest live channel, and nearest live channel after idx (cyclic; idx itself if alone).
  always_comb begin
    first_idx = '0;
    for (int k = W - 1; k >= 0; k--)
      if (live[k]) first_idx = N'(k);
    adv_idx = idx;
    for (int k = W - 1; k >= 1; k--)
      if (live[N'(int'(idx) + k)]) adv_idx = N'(int'(idx) + k);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      out   <= '0;
      idx   <= '0;
      wrap  <= 1'b0;
    end else begin
      state <= state_next;
      out   <= out_next;
      idx   <= idx_next;
      wrap  <= wrap_next;
    end
  end

  always_comb begin
    if (!en)
      state_next = IDLE;
    else if (!mode)
      state_next = DIRECT;
    else
      state_next = SCAN;
  end

  always_comb begin
    out_next  = '0;
    idx_next  = '0;
    wrap_next = 1'b0;
    case (state_next)
      DIRECT: begin
        idx_next = in;
        out_next = W'(onehot(MAX_N'(in)));
      end
      SCAN: begin
        if (!any_live) begin
          out_next = '0;
        end else if (state != SCAN || stalled) begin
          idx_next = first_idx;
          out_next = W'(onehot(MAX_N'(first_idx)));
        end else if (tick) begin
          idx_next  = adv_idx;
          out_next  = W'(onehot(MAX_N'(adv_idx)));
          wrap_next = (adv_idx <= idx);
        end else begin
          idx_next = idx;
          out_next = out;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_decoder_nx_seq.sv
// Scoreboard bench for decoder_nx_seq: N=3/DWELL=4 and N=2/DWELL=1 instances.
module tb_decoder_nx_seq;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       en_a, mode_a;
  logic [2:0] in_a;
  logic [7:0] out_a;
  logic [2:0] idx_a;
  logic       wrap_a;

  logic       en_b, mode_b;
  logic [1:0] in_b;
  logic [3:0] out_b;
  logic [1:0] idx_b;
  logic       wrap_b;

`ifdef DEC_SCAN_MASK_EN
  logic [7:0] mask_a;
  logic [3:0] mask_b;
`endif

  decoder_nx_seq #(.N(3), .DWELL(4)) u_a (
    .clk  (clk),
    .rst  (rst),
    .en   (en_a),
    .mode (mode_a),
    .in   (in_a),
`ifdef DEC_SCAN_MASK_EN
    .mask (mask_a),
`endif
    .out  (out_a),
    .idx  (idx_a),
    .wrap (wrap_a)
  );

  decoder_nx_seq #(.N(2), .DWELL(1)) u_b (
    .clk  (clk),
    .rst  (rst),
    .en   (en_b),
    .mode (mode_b),
    .in   (in_b),
`ifdef DEC_SCAN_MASK_EN
    .mask (mask_b),
`endif
    .out  (out_b),
    .idx  (idx_b),
    .wrap (wrap_b)
  );

  typedef struct {
    bit          dut_b;
    string       tag;
    logic [11:0] exp;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;

  task automatic push(input bit b, input string tag, input logic [7:0] o,
                      input logic [2:0] i, input logic w);
    exp_t e;
    e.dut_b = b;
    e.tag   = tag;
    e.exp   = {o, i, w};
    sb.push_back(e);
  endtask

  task automatic drain();
    exp_t        e;
    logic [11:0] obs;
    while (sb.size() > 0) begin
      e   = sb.pop_front();
      obs = e.dut_b ? {4'h0, out_b, 1'b0, idx_b, wrap_b} : {out_a, idx_a, wrap_a};
      n_cmp++;
      $display("[%0d] %s out=%h idx=%0d wrap=%b", cyc, e.tag, obs[11:4], obs[3:1], obs[0]);
      assert (obs === e.exp) else begin
        n_bad++;
        $error("FAIL %s observed out=%h idx=%0d wrap=%b expected out=%h idx=%0d wrap=%b",
               e.tag, obs[11:4], obs[3:1], obs[0], e.exp[11:4], e.exp[3:1], e.exp[0]);
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    drain();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    en_a = 1'b0; mode_a = 1'b0; in_a = '0;
    en_b = 1'b0; mode_b = 1'b0; in_b = '0;
`ifdef DEC_SCAN_MASK_EN
    mask_a = '0; mask_b = '0;
`endif
    #1;
    push(0, "reset_a", 8'h00, 3'd0, 1'b0);
    push(1, "reset_b", 8'h00, 3'd0, 1'b0);
    drain();
    @(posedge clk); #1;
    rst = 1'b0;

    repeat (3) begin
      push(0, "idle", 8'h00, 3'd0, 1'b0);
      step();
    end

    en_a = 1'b1; mode_a = 1'b0;
    for (int i = 0; i < 8; i++) begin
      in_a = 3'(i);
      for (int c = 0; c < 10; c++) begin
        push(0, "direct", 8'(1 << i), 3'(i), 1'b0);
        step();
      end
    end

    // Scan for 90 visible cycles so the last one sits on idx 6.
    mode_a = 1'b1;
    for (int t = 0; t < 90; t++) begin
      push(0, "scan", 8'(1 << ((t / 4) % 8)), 3'((t / 4) % 8), (t > 0 && t % 32 == 0));
      step();
    end

    in_a = 3'd5; mode_a = 1'b0;
    push(0, "mode_to_direct", 8'h20, 3'd5, 1'b0);
    step();

    mode_a = 1'b1;
    for (int t = 0; t < 6; t++) begin
      push(0, "rescan", 8'(1 << ((t / 4) % 8)), 3'((t / 4) % 8), 1'b0);
      step();
    end

    rst = 1'b1;
    #1;
    push(0, "async_rst", 8'h00, 3'd0, 1'b0);
    drain();
    @(posedge clk); #1;
    rst = 1'b0;
    for (int t = 0; t < 6; t++) begin
      push(0, "post_rst_scan", 8'(1 << ((t / 4) % 8)), 3'((t / 4) % 8), 1'b0);
      step();
    end

    en_a = 1'b0;
    repeat (3) begin
      push(0, "en_low", 8'h00, 3'd0, 1'b0);
      step();
    end

    en_b = 1'b1; mode_b = 1'b1;
    for (int t = 0; t < 12; t++) begin
      push(1, "scan_dwell1", 8'(1 << (t % 4)), 3'(t % 4), (t > 0 && t % 4 == 0));
      step();
    end

`ifdef DEC_SCAN_MASK_EN
    mask_a = 8'hF6; en_a = 1'b1; mode_a = 1'b1;
    for (int t = 0; t < 24; t++) begin
      push(0, "mask_f6", ((t / 4) % 2 == 1) ? 8'h08 : 8'h01,
           ((t / 4) % 2 == 1) ? 3'd3 : 3'd0, (t > 0 && t % 8 == 0));
      step();
    end
    mask_a = 8'hFF;
    repeat (5) begin
      push(0, "mask_all", 8'h00, 3'd0, 1'b0);
      step();
    end
    mask_a = 8'hEF;
    for (int t = 0; t < 9; t++) begin
      push(0, "mask_single", 8'h10, 3'd4, (t > 0 && t % 4 == 0));
      step();
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
